// File: rtl/axi2wb.sv
// axi2wb: AXI4 slave to Wishbone B4 classic master bridge; one AXI transaction at a time,
// one classic Wishbone cycle per beat. Define AXI2WB_TIMEOUT_EN to enable the Wishbone watchdog.
module axi2wb #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int AXI_ID_WIDTH = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [ADDR_WIDTH-1:0]     wb_adr_o,
  output logic [DATA_WIDTH-1:0]     wb_dat_o,
  output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
  output logic [2:0]                wb_cti_o,
  output logic [1:0]                wb_bte_o,
  input  logic [DATA_WIDTH-1:0]     wb_dat_i,
  input  logic                      wb_ack_i,
  input  logic                      wb_err_i,
  input  logic                      wb_rty_i
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_WB, WR_RESP, RD_WB, RD_DATA} state_t;

  state_t                  state, state_nx;
  logic [AXI_ID_WIDTH-1:0] id_r;
  logic [ADDR_WIDTH-1:0]   addr_r, next_addr;
  logic [7:0]              len_r, cnt_r;
  logic [2:0]              size_r;
  logic [1:0]              burst_r;
  logic [DATA_WIDTH-1:0]   wdata_r, rdata_r;
  logic [SEL_W-1:0]        wstrb_r;
  logic [1:0]              rresp_r, acc_r, beat_resp;
  logic                    last_rd_r, gap_r;
  logic                    sel_wr, aw_hs, ar_hs, in_wb, bad_burst, stb_act;
  logic                    beat_done, beat_retry, is_last, timeout_hit;
  logic                    unused_in;

  // Alternating priority: on a tie, the channel not served last wins.
  assign sel_wr     = s_axi_awvalid & (~s_axi_arvalid | last_rd_r);
  assign aw_hs      = (state == IDLE) & sel_wr;
  assign ar_hs      = (state == IDLE) & ~sel_wr & s_axi_arvalid;
  assign in_wb      = (state == WR_WB) | (state == RD_WB);
  assign bad_burst  = burst_r[1];
  assign stb_act    = in_wb & ~gap_r & ~bad_burst;
  assign beat_done  = in_wb & ~gap_r & (bad_burst | wb_ack_i | wb_err_i | timeout_hit);
  assign beat_retry = stb_act & wb_rty_i & ~wb_ack_i & ~wb_err_i;
  assign is_last    = (cnt_r == len_r);
  assign next_addr  = (burst_r == BURST_FIXED) ? addr_r : addr_r + (ADDR_WIDTH'(1) << size_r);

  always_comb begin
    beat_resp = RESP_OKAY;
    if (bad_burst)                   beat_resp = RESP_SLVERR;
    else if (timeout_hit)            beat_resp = RESP_DECERR;
    else if (wb_err_i)               beat_resp = RESP_SLVERR;
  end

`ifdef AXI2WB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_r;
  logic            wb_term;
  assign wb_term     = wb_ack_i | wb_err_i | wb_rty_i;
  assign timeout_hit = stb_act & ~wb_term & (wd_r == WD_W'(TIMEOUT - 1));
  assign unused_in   = s_axi_wlast;
  always_ff @(posedge clk) begin
    if (rst || !stb_act || wb_term) wd_r <= '0;
    else                            wd_r <= wd_r + WD_W'(1);
  end
`else
  assign timeout_hit = 1'b0;
  assign unused_in   = s_axi_wlast ^ (TIMEOUT == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (aw_hs) state_nx = WR_DATA;
               else if (ar_hs) state_nx = RD_WB;
      WR_DATA: if (s_axi_wvalid) state_nx = WR_WB;
      WR_WB:   if (beat_done) state_nx = is_last ? WR_RESP : WR_DATA;
      WR_RESP: if (s_axi_bready) state_nx = IDLE;
      RD_WB:   if (beat_done) state_nx = RD_DATA;
      RD_DATA: if (s_axi_rready) state_nx = is_last ? IDLE : RD_WB;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = aw_hs;
    s_axi_arready = ar_hs;
    s_axi_wready  = (state == WR_DATA);
    s_axi_bvalid  = (state == WR_RESP);
    s_axi_rvalid  = (state == RD_DATA);
    s_axi_rlast   = (state == RD_DATA) & is_last;
    wb_cyc_o      = stb_act;
    wb_stb_o      = stb_act;
    wb_we_o       = stb_act & (state == WR_WB);
    wb_sel_o      = (state == RD_WB) ? {SEL_W{1'b1}} : wstrb_r;
  end

  assign wb_adr_o    = addr_r;
  assign wb_dat_o    = wdata_r;
  assign wb_cti_o    = 3'b000;
  assign wb_bte_o    = 2'b00;
  assign s_axi_bid   = id_r;
  assign s_axi_rid   = id_r;
  assign s_axi_bresp = acc_r;
  assign s_axi_rresp = rresp_r;
  assign s_axi_rdata = rdata_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_r      <= '0;
      addr_r    <= '0;
      len_r     <= '0;
      size_r    <= '0;
      burst_r   <= '0;
      cnt_r     <= '0;
      wdata_r   <= '0;
      wstrb_r   <= '0;
      rdata_r   <= '0;
      rresp_r   <= RESP_OKAY;
      acc_r     <= RESP_OKAY;
      last_rd_r <= 1'b1;
      gap_r     <= 1'b0;
    end else begin
      gap_r <= beat_retry;
      if (aw_hs || ar_hs) begin
        id_r      <= aw_hs ? s_axi_awid    : s_axi_arid;
        addr_r    <= aw_hs ? s_axi_awaddr  : s_axi_araddr;
        len_r     <= aw_hs ? s_axi_awlen   : s_axi_arlen;
        size_r    <= aw_hs ? s_axi_awsize  : s_axi_arsize;
        burst_r   <= aw_hs ? s_axi_awburst : s_axi_arburst;
        cnt_r     <= '0;
        acc_r     <= RESP_OKAY;
        last_rd_r <= ar_hs;
      end
      if (state == WR_DATA && s_axi_wvalid) begin
        wdata_r <= s_axi_wdata;
        wstrb_r <= s_axi_wstrb;
      end
      if (beat_done && state == WR_WB) begin
        // DECERR is sticky over SLVERR in the accumulated write response.
        if (beat_resp == RESP_DECERR || acc_r == RESP_DECERR) acc_r <= RESP_DECERR;
        else if (beat_resp == RESP_SLVERR)                    acc_r <= RESP_SLVERR;
        if (!is_last) begin
          cnt_r  <= cnt_r + 8'd1;
          addr_r <= next_addr;
        end
      end
      if (beat_done && state == RD_WB) begin
        rdata_r <= bad_burst ? '0 : wb_dat_i;
        rresp_r <= beat_resp;
      end
      if (state == RD_DATA && s_axi_rready && !is_last) begin
        cnt_r  <= cnt_r + 8'd1;
        addr_r <= next_addr;
      end
    end
  end

endmodule

// File: tb/tb_axi2wb.sv
// Self-checking bench for axi2wb: table of single-beat vectors plus hand-written burst,
// arbitration, retry/backpressure, wrap-around and (with AXI2WB_TIMEOUT_EN) watchdog sequences.
module tb_axi2wb;
  localparam int R_ACK = 0, R_ERR = 1, R_RTY = 2, R_NONE = 3;

  logic        clk, rst;
  logic [0:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata, wb_adr, wb_dat_o, wb_dat_i;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, wb_cti;
  logic [1:0]  awburst, arburst, bresp, rresp, wb_bte;
  logic [3:0]  wstrb, wb_sel;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        wb_cyc, wb_stb, wb_we, wb_ack_i, wb_err_i, wb_rty_i;

  axi2wb #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .AXI_ID_WIDTH(1), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready), .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_cti_o(wb_cti), .wb_bte_o(wb_bte),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Slave script (written by the stimulus) and access log (written by the slave model).
  int          slv_rsp [0:255];
  logic [31:0] slv_dat [0:255];
  int          sq_tl = 0, flush_to = 0, sq_hd = 0;
  logic [31:0] lg_adr [0:255];
  logic [31:0] lg_dat [0:255];
  logic [3:0]  lg_sel [0:255];
  logic        lg_we  [0:255];
  int          lg_t   [0:255];
  int          lg_n = 0, stb_cnt = 0;

  initial begin
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
  end

  always @(negedge clk) begin : slave
    int hd;
    int r;
    hd = (sq_hd < flush_to) ? flush_to : sq_hd;
    if ((wb_ack_i || wb_err_i || wb_rty_i) && hd < sq_tl) hd = hd + 1;
    sq_hd    <= hd;
    wb_ack_i <= 1'b0;
    wb_err_i <= 1'b0;
    wb_rty_i <= 1'b0;
    if (wb_cyc && wb_stb) begin
      stb_cnt  <= stb_cnt + 1;
      r = (hd < sq_tl) ? slv_rsp[hd] : R_ACK;
      wb_dat_i <= (hd < sq_tl) ? slv_dat[hd] : 32'hBAD0BAD0;
      wb_ack_i <= (r == R_ACK);
      wb_err_i <= (r == R_ERR);
      wb_rty_i <= (r == R_RTY);
      if (r != R_NONE && lg_n < 256) begin
        lg_adr[lg_n] <= wb_adr;
        lg_dat[lg_n] <= wb_dat_o;
        lg_sel[lg_n] <= wb_sel;
        lg_we[lg_n]  <= wb_we;
        lg_t[lg_n]   <= cyc_n;
        lg_n         <= lg_n + 1;
      end
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic push(input int r, input logic [31:0] d);
    slv_rsp[sq_tl] = r;
    slv_dat[sq_tl] = d;
    sq_tl++;
  endtask

  function automatic bit rdy(input int ch);
    case (ch)
      0: return awready;
      1: return wready;
      2: return bvalid;
      3: return arready;
      default: return rvalid;
    endcase
  endfunction

  task automatic wait_rdy(input int ch, input string nm, output int stamp);
    int n;
    n = 0;
    stamp = -1;
    forever begin
      @(negedge clk);
      if (rdy(ch)) begin
        stamp = cyc_n;
        break;
      end
      n++;
      if (n > 300) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: handshake timed out", nm);
        break;
      end
    end
  endtask

  logic [31:0] wq [0:15];
  logic [3:0]  wstrb_g;
  logic [1:0]  got_bresp;
  logic [0:0]  got_bid, rd_id;
  logic [31:0] rd_d [0:15];
  logic [1:0]  rd_r [0:15];
  logic        rd_l [0:15];
  int          t_a, t_w, t_b, t_ar, t_r;
  logic        ar_rdy_at, aw_rdy_at;

  task automatic aw_phase(input logic [0:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu);
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
    wait_rdy(0, "aw_hs", t_a);
    ar_rdy_at = arready;
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_phase(input logic [7:0] len);
    int t;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wq[i]; wstrb = wstrb_g; wlast = (i == int'(len)); wvalid = 1'b1;
      wait_rdy(1, "w_hs", t);
      if (i == 0) t_w = t;
      @(posedge clk); #1;
      wvalid = 1'b0;
    end
  endtask

  task automatic b_phase();
    bready = 1'b1;
    wait_rdy(2, "b_hs", t_b);
    got_bresp = bresp;
    got_bid   = bid;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic ar_phase(input logic [0:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu);
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
    wait_rdy(3, "ar_hs", t_ar);
    aw_rdy_at = awready;
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic r_phase(input logic [7:0] len, input int stall);
    int t;
    rready = (stall == 0);
    for (int i = 0; i <= int'(len); i++) begin
      wait_rdy(4, "r_hs", t);
      if (i == 0) t_r = t;
      rd_d[i] = rdata; rd_r[i] = rresp; rd_l[i] = rlast; rd_id = rid;
      if (i == 0 && stall > 0) begin
        repeat (stall) begin
          @(posedge clk); #1;
          @(negedge clk);
          chk("r_hold_valid", rvalid, 1'b1);
          chk("r_hold_data", rdata, rd_d[0]);
        end
        @(posedge clk); #1;
        rready = 1'b1;
        @(negedge clk);
      end
      @(posedge clk); #1;
    end
    rready = 1'b0;
  endtask

  task automatic do_write(input logic [0:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu);
    aw_phase(id, a, len, sz, bu);
    w_phase(len);
    b_phase();
  endtask

  task automatic do_read(input logic [0:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu, input int stall);
    ar_phase(id, a, len, sz, bu);
    r_phase(len, stall);
  endtask

  typedef struct {
    bit          is_wr;
    logic [0:0]  id;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  burst;
    int          rsp;
    logic [1:0]  exp_resp;
    bit          exp_acc;
  } vec_t;

  initial begin : main
    vec_t vt [7];
    int   base;
    int   s0;

    vt[0] = '{1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 2'b01, R_ACK, 2'b00, 1'b1};
    vt[1] = '{1'b1, 1'b0, 32'h104, 32'h0000CAFE, 4'h3, 2'b01, R_ERR, 2'b10, 1'b1};
    vt[2] = '{1'b0, 1'b1, 32'h200, 32'h12345678, 4'hF, 2'b01, R_ACK, 2'b00, 1'b1};
    vt[3] = '{1'b0, 1'b0, 32'h300, 32'h0BADF00D, 4'hF, 2'b00, R_ERR, 2'b10, 1'b1};
    vt[4] = '{1'b1, 1'b1, 32'h400, 32'h55AA55AA, 4'h8, 2'b10, R_ACK, 2'b10, 1'b0};
    vt[5] = '{1'b0, 1'b1, 32'h500, 32'h00000000, 4'hF, 2'b11, R_ACK, 2'b10, 1'b0};
    vt[6] = '{1'b1, 1'b0, 32'h600, 32'h12345678, 4'h5, 2'b00, R_ACK, 2'b00, 1'b1};

    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    wstrb_g = 4'hF;
    rst = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_handshakes", {awready, arready, wready, bvalid, rvalid}, 5'b0);
    chk("rst_wb_ctrl", {wb_cyc, wb_stb, wb_we}, 3'b0);
    chk("rst_resp", {bresp, rresp}, 4'b0);
    chk("wb_cti_bte", {wb_cti, wb_bte}, 5'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Tie straight after reset: write wins, then the pending read.
    base = lg_n;
    push(R_ACK, 32'h0); push(R_ACK, 32'h00001111);
    arid = 1'b0; araddr = 32'h20; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    wq[0] = 32'hAAAA0001;
    aw_phase(1'b0, 32'h10, 8'd0, 3'd2, 2'b01);
    chk("tie1_ar_blocked", ar_rdy_at, 1'b0);
    w_phase(8'd0);
    b_phase();
    ar_phase(1'b0, 32'h20, 8'd0, 3'd2, 2'b01);
    r_phase(8'd0, 0);
    chk("tie1_order", {lg_we[base], lg_we[base+1]}, 2'b10);
    chk("tie1_rdata", rd_d[0], 32'h00001111);
    // Lone write, then tie: read must win this time.
    push(R_ACK, 32'h0);
    do_write(1'b0, 32'h30, 8'd0, 3'd2, 2'b01);
    base = lg_n;
    push(R_ACK, 32'h00002222); push(R_ACK, 32'h0);
    awid = 1'b1; awaddr = 32'h40; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    ar_phase(1'b1, 32'h50, 8'd0, 3'd2, 2'b01);
    chk("tie2_aw_blocked", aw_rdy_at, 1'b0);
    r_phase(8'd0, 0);
    aw_phase(1'b1, 32'h40, 8'd0, 3'd2, 2'b01);
    w_phase(8'd0);
    b_phase();
    chk("tie2_order", {lg_we[base], lg_we[base+1]}, 2'b01);
    flush_to = sq_tl;

    // Zero-wait latency.
    base = lg_n;
    push(R_ACK, 32'h0);
    wq[0] = 32'hDEADBEEF;
    do_write(1'b1, 32'h100, 8'd0, 3'd2, 2'b01);
    chk("lat_w_accept", t_w - t_a, 1);
    chk("lat_w_wb", lg_t[base] - t_a, 2);
    chk("lat_w_bvalid", t_b - t_a, 3);
    base = lg_n;
    push(R_ACK, 32'h0000ABCD);
    do_read(1'b0, 32'h104, 8'd0, 3'd2, 2'b01, 0);
    chk("lat_r_wb", lg_t[base] - t_ar, 1);
    chk("lat_r_rvalid", t_r - t_ar, 2);

    // Single-beat vector table.
    for (int i = 0; i < 7; i++) begin
      base = lg_n;
      push(vt[i].rsp, vt[i].is_wr ? 32'h0 : vt[i].data);
      if (vt[i].is_wr) begin
        wq[0] = vt[i].data;
        wstrb_g = vt[i].strb;
        do_write(vt[i].id, vt[i].addr, 8'd0, 3'd2, vt[i].burst);
        chk($sformatf("vec%0d_bresp", i), got_bresp, vt[i].exp_resp);
        chk($sformatf("vec%0d_bid", i), got_bid, vt[i].id);
      end else begin
        do_read(vt[i].id, vt[i].addr, 8'd0, 3'd2, vt[i].burst, 0);
        chk($sformatf("vec%0d_rresp", i), rd_r[0], vt[i].exp_resp);
        chk($sformatf("vec%0d_rid", i), rd_id, vt[i].id);
        chk($sformatf("vec%0d_rlast", i), rd_l[0], 1'b1);
      end
      flush_to = sq_tl;
      chk($sformatf("vec%0d_naccess", i), lg_n - base, vt[i].exp_acc ? 1 : 0);
      if (vt[i].exp_acc && lg_n > base) begin
        chk($sformatf("vec%0d_adr", i), lg_adr[base], vt[i].addr);
        chk($sformatf("vec%0d_we", i), lg_we[base], vt[i].is_wr);
        if (vt[i].is_wr) begin
          chk($sformatf("vec%0d_dat", i), lg_dat[base], vt[i].data);
          chk($sformatf("vec%0d_sel", i), lg_sel[base], vt[i].strb);
        end else begin
          chk($sformatf("vec%0d_sel", i), lg_sel[base], 4'hF);
          chk($sformatf("vec%0d_rdata", i), rd_d[0], vt[i].data);
        end
      end
    end
    wstrb_g = 4'hF;

    // INCR read, four beats.
    base = lg_n;
    for (int i = 0; i < 4; i++) push(R_ACK, 32'h11 * (i + 1));
    do_read(1'b1, 32'h200, 8'd3, 3'd2, 2'b01, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("incr_adr%0d", i), lg_adr[base+i], 32'h200 + 4 * i);
      chk($sformatf("incr_data%0d", i), rd_d[i], 32'h11 * (i + 1));
      chk($sformatf("incr_rlast%0d", i), rd_l[i], i == 3);
      chk($sformatf("incr_rresp%0d", i), rd_r[i], 2'b00);
    end

    // Error on beat 0 of a two-beat write and read.
    base = lg_n;
    push(R_ERR, 32'h0); push(R_ACK, 32'h0);
    wq[0] = 32'hA0A0A0A0; wq[1] = 32'hA1A1A1A1;
    do_write(1'b0, 32'h40, 8'd1, 3'd2, 2'b01);
    chk("werr_naccess", lg_n - base, 2);
    chk("werr_adr1", lg_adr[base+1], 32'h44);
    chk("werr_dat1", lg_dat[base+1], 32'hA1A1A1A1);
    chk("werr_bresp", got_bresp, 2'b10);
    push(R_ERR, 32'h77); push(R_ACK, 32'h88);
    do_read(1'b0, 32'h80, 8'd1, 3'd2, 2'b01, 0);
    chk("rerr_resp", {rd_r[0], rd_r[1]}, 4'b1000);
    chk("rerr_data1", rd_d[1], 32'h88);

    // Retry then ack, with R backpressure.
    base = lg_n;
    push(R_RTY, 32'h0); push(R_ACK, 32'hA5A5A5A5);
    do_read(1'b1, 32'h300, 8'd0, 3'd2, 2'b01, 3);
    chk("rty_attempts", lg_n - base, 2);
    chk("rty_same_adr", lg_adr[base+1], 32'h300);
    chk("rty_gap", lg_t[base+1] - lg_t[base], 2);
    chk("rty_rdata", rd_d[0], 32'hA5A5A5A5);
    chk("rty_rresp", rd_r[0], 2'b00);

    // FIXED write burst.
    base = lg_n;
    for (int i = 0; i < 3; i++) begin
      push(R_ACK, 32'h0);
      wq[i] = 32'hF000 + i;
    end
    do_write(1'b0, 32'h700, 8'd2, 3'd2, 2'b00);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fixed_adr%0d", i), lg_adr[base+i], 32'h700);
      chk($sformatf("fixed_dat%0d", i), lg_dat[base+i], 32'hF000 + i);
    end

    // INCR address wraps at the top of the address space; byte-sized INCR.
    base = lg_n;
    push(R_ACK, 32'h1); push(R_ACK, 32'h2); push(R_ACK, 32'h3); push(R_ACK, 32'h4);
    do_read(1'b0, 32'hFFFFFFFC, 8'd1, 3'd2, 2'b01, 0);
    do_read(1'b0, 32'h10, 8'd1, 3'd0, 2'b01, 0);
    chk("wrap_adr1", lg_adr[base+1], 32'h0);
    chk("size0_adr1", lg_adr[base+3], 32'h11);

    // WRAP burst write: all W beats consumed, no Wishbone access, SLVERR.
    base = lg_n;
    wq[0] = 32'h1; wq[1] = 32'h2;
    do_write(1'b1, 32'h900, 8'd1, 3'd2, 2'b10);
    chk("wrapb_naccess", lg_n - base, 0);
    chk("wrapb_bresp", got_bresp, 2'b10);

`ifdef AXI2WB_TIMEOUT_EN
    s0 = stb_cnt;
    push(R_NONE, 32'h0);
    do_read(1'b0, 32'hA00, 8'd0, 3'd2, 2'b01, 0);
    flush_to = sq_tl;
    chk("wdog_stb_cycles", stb_cnt - s0, 8);
    chk("wdog_rresp", rd_r[0], 2'b11);
    push(R_ACK, 32'h5A5A);
    do_read(1'b0, 32'hA04, 8'd0, 3'd2, 2'b01, 0);
    chk("wdog_after", {rd_r[0], rd_d[0]}, {2'b00, 32'h5A5A});
`endif

    // Reset during a write aborts it without a response.
    aw_phase(1'b0, 32'hB00, 8'd0, 3'd2, 2'b01);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_quiet", {wready, bvalid, wb_cyc}, 3'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    push(R_ACK, 32'hC0C0);
    do_read(1'b0, 32'hB04, 8'd0, 3'd2, 2'b01, 0);
    chk("abort_recover", rd_d[0], 32'hC0C0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
